// File: rtl/arb_pkg.sv
// Shared types and helpers for the ring token arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Widest ring the rotate helper supports.
    localparam int RING_MAX = 64;

    // Rotate the low n bits of a one-hot vector left by one, wrapping bit n-1 to bit 0.
    function automatic logic [RING_MAX-1:0] rot_left1(input logic [RING_MAX-1:0] v, input int n);
        logic [RING_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < RING_MAX; i++) begin
            if (i < n) begin
                r[i] = v[(i + n - 1) % n];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after the one-hot token, wrapping.
// Double-width trick: the upper copy of req covers the wrapped part of the scan.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   ptr,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_id,
    output logic           any
);

    logic [2*N-1:0] dbl;

    // Lower copy keeps only requests at or above the token position.
    assign dbl = {req, req & ~(ptr - N'(1))};
    assign any = |req;

    // Lowest set bit of the double-width vector wins; fold its index back into the ring.
    always_comb begin
        win    = '0;
        win_id = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                win_id = IDW'(i % N);
            end
        end
        if (any) begin
            win[win_id] = 1'b1;
        end
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and a bounded hold time.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; pick next requester from the token on req != 0
//   GRANT | owner holds the resource until release, req drop or limit
//
// The owner's release strobe is the port "rel" ("release" is reserved).
module ring_token_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16,
    parameter int IDW      = $clog2(N),
    parameter int CW       = $clog2(HOLD_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    // Counter needs at least one bit even when the timeout is disabled.
    localparam int CWI = (CW < 1) ? 1 : CW;
    localparam int LIM = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [CWI-1:0] LIM_C = CWI'(LIM);

    state_t         state, state_n;
    logic [N-1:0]   ptr, ptr_n;
    logic [CWI-1:0] cnt, cnt_n;
    logic [N-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic           busy_n, timeout_n;

    logic [N-1:0]   win;
    logic [IDW-1:0] win_id;
    logic           any;
    logic           rel_ev, lim_hit;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .win    (win),
        .win_id (win_id),
        .any    (any)
    );

    assign rel_ev  = rel | ~req[gnt_id];
    assign lim_hit = (HOLD_MAX != 0) && (cnt == LIM_C);

    // State, token, hold counter and all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= N'(1);
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

    // Next-state and next-output decode; a release wins over a coincident limit.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        busy_n    = busy;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    gnt_n    = win;
                    gnt_id_n = win_id;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                if (rel_ev || lim_hit) begin
                    gnt_n     = '0;
                    busy_n    = 1'b0;
                    ptr_n     = N'(rot_left1(RING_MAX'(gnt), N));
                    timeout_n = lim_hit & ~rel_ev;
                    state_n   = IDLE;
                end else if (HOLD_MAX != 0) begin
                    cnt_n = cnt + CWI'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
